// File: rtl/tbps_crc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tbps_crc_pkg
// Description : Shared constants and helpers for the CRC match stage.
// Revision    : 1.0 - initial release
// ============================================================================
package tbps_crc_pkg;

  // Bit positions inside the {missing, pass} result word
  localparam int RES_PASS_BIT    = 0;
  localparam int RES_MISSING_BIT = 1;

  // Reverse the low w bits of v; bits at and above w are returned as zero
  function automatic logic [63:0] bitrev(logic [63:0] v, int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < w) begin
        r[i] = v[w-1-i];
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tbps_crc_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tbps_crc_sync_fifo
// Description : Single-clock FIFO, first-word-fall-through head read from the
//               storage registers. Pointers carry one extra wrap bit so that
//               full and empty can be told apart without a separate counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tbps_crc_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign level_o   = wr_ptr_q - rd_ptr_q;
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (level_o == (AW+1)'(DEPTH));
  assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

  // Full blocks a push even when a pop happens in the same cycle
  assign w_push_ok = push_i && !full_o;
  assign w_pop_ok  = pop_i && !empty_o;

  // Pointer next-state: each advances independently, wrapping naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (w_pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers; reset empties the queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tbps_crc_match.sv
`default_nettype none
// ============================================================================
// Module      : tbps_crc_match
// Description : Post-processes each raw frame CRC (REFOUT, XOR_OUT), compares
//               it in order against queued expected FCS values and reports a
//               {missing, pass} result with saturating ok/bad statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module tbps_crc_match
  import tbps_crc_pkg::*;
#(
  parameter int          CRC_WIDTH  = 32,
  parameter logic [63:0] XOR_OUT    = 64'hffffffff,
  parameter bit          REFOUT     = 1'b0,
  parameter int          FIFO_DEPTH = 16,
  parameter int          CNT_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CRC_WIDTH-1:0]          i_fcs_axis_tdata,
  input  logic                          i_fcs_axis_tvalid,
  output logic                          i_fcs_axis_tready,
  input  logic [CRC_WIDTH-1:0]          i_crc_axis_tdata,
  input  logic                          i_crc_axis_tvalid,
  output logic [1:0]                    o_res_axis_tdata,
  output logic                          o_res_axis_tvalid,
  output logic [CNT_WIDTH-1:0]          o_ok_cnt,
  output logic [CNT_WIDTH-1:0]          o_bad_cnt,
  output logic                          o_underflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int          LVL_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [63:0] CRC_MASK = (CRC_WIDTH >= 64) ? {64{1'b1}}
                                                       : ((64'd1 << CRC_WIDTH) - 64'd1);

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [CRC_WIDTH-1:0] w_head;
  logic [LVL_W-1:0]     w_level;
  logic [63:0]          w_crc64;
  logic [63:0]          w_fin64;
  logic                 w_match;

  logic                 ready_q,     ready_d;
  logic                 res_valid_q, res_valid_d;
  logic [1:0]           res_q,       res_d;
  logic [CNT_WIDTH-1:0] ok_cnt_q,    ok_cnt_d;
  logic [CNT_WIDTH-1:0] bad_cnt_q,   bad_cnt_d;
  logic                 underflow_q, underflow_d;

  // Ready comes from registered state only: out-of-reset flag and queue full
  assign i_fcs_axis_tready = ready_q && !w_full;
  assign w_push            = i_fcs_axis_tvalid && i_fcs_axis_tready;
  assign w_pop             = i_crc_axis_tvalid && !w_empty;

  tbps_crc_sync_fifo #(
    .WIDTH (CRC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fcs_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_push),
    .wdata_i (i_fcs_axis_tdata),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (w_level)
  );

  // Work in 64 bits so the width-generic reverse and XOR share one path;
  // the mask discards bits above CRC_WIDTH before comparing
  assign w_crc64 = 64'(i_crc_axis_tdata);
  assign w_fin64 = (REFOUT ? bitrev(w_crc64, CRC_WIDTH) : w_crc64) ^ XOR_OUT;
  assign w_match = (((w_fin64 ^ 64'(w_head)) & CRC_MASK) == 64'd0);

  // Result and statistics next-state; counters saturate at all-ones
  always_comb begin
    ready_d     = 1'b1;
    res_valid_d = i_crc_axis_tvalid;
    res_d       = '0;
    ok_cnt_d    = ok_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    underflow_d = underflow_q;
    if (i_crc_axis_tvalid) begin
      if (w_empty) begin
        res_d[RES_MISSING_BIT] = 1'b1;
        underflow_d            = 1'b1;
      end else begin
        res_d[RES_PASS_BIT] = w_match;
      end
      if (res_d[RES_PASS_BIT]) begin
        if (ok_cnt_q != {CNT_WIDTH{1'b1}}) ok_cnt_d = ok_cnt_q + CNT_WIDTH'(1);
      end else begin
        if (bad_cnt_q != {CNT_WIDTH{1'b1}}) bad_cnt_d = bad_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // Result and statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      ok_cnt_q    <= '0;
      bad_cnt_q   <= '0;
      underflow_q <= 1'b0;
    end else begin
      ready_q     <= ready_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      ok_cnt_q    <= ok_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      underflow_q <= underflow_d;
    end
  end

  assign o_res_axis_tvalid = res_valid_q;
  assign o_res_axis_tdata  = res_q;
  assign o_ok_cnt          = ok_cnt_q;
  assign o_bad_cnt         = bad_cnt_q;
  assign o_underflow       = underflow_q;
  assign o_level           = w_level;

endmodule
`default_nettype wire

// File: tb/tb_tbps_crc_match.sv
`default_nettype none
// ============================================================================
// Module      : tb_tbps_crc_match
// Description : Directed self-checking bench for tbps_crc_match. Instance A
//               uses the default configuration, instance B uses REFOUT=1,
//               XOR_OUT=0 and 4-bit counters for saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tbps_crc_match;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [31:0] a_fcs, a_crc;
  logic        a_fcs_v, a_crc_v, a_tready, a_res_v, a_unf;
  logic [1:0]  a_res;
  logic [31:0] a_ok, a_bad;
  logic [4:0]  a_level;

  logic [31:0] b_fcs, b_crc;
  logic        b_fcs_v, b_crc_v, b_tready, b_res_v, b_unf;
  logic [1:0]  b_res;
  logic [3:0]  b_ok, b_bad;
  logic [4:0]  b_level;

  int          n_chk  = 0;
  int          n_fail = 0;

  logic [31:0] model_q [$];
  int          nidx;
  bit          acc;

  always #5 clk = ~clk;

  tbps_crc_match #(
    .CRC_WIDTH(32), .XOR_OUT(64'hffffffff), .REFOUT(1'b0),
    .FIFO_DEPTH(16), .CNT_WIDTH(32)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .i_fcs_axis_tdata(a_fcs), .i_fcs_axis_tvalid(a_fcs_v), .i_fcs_axis_tready(a_tready),
    .i_crc_axis_tdata(a_crc), .i_crc_axis_tvalid(a_crc_v),
    .o_res_axis_tdata(a_res), .o_res_axis_tvalid(a_res_v),
    .o_ok_cnt(a_ok), .o_bad_cnt(a_bad), .o_underflow(a_unf), .o_level(a_level)
  );

  tbps_crc_match #(
    .CRC_WIDTH(32), .XOR_OUT(64'h0), .REFOUT(1'b1),
    .FIFO_DEPTH(16), .CNT_WIDTH(4)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_fcs_axis_tdata(b_fcs), .i_fcs_axis_tvalid(b_fcs_v), .i_fcs_axis_tready(b_tready),
    .i_crc_axis_tdata(b_crc), .i_crc_axis_tvalid(b_crc_v),
    .o_res_axis_tdata(b_res), .o_res_axis_tvalid(b_res_v),
    .o_ok_cnt(b_ok), .o_bad_cnt(b_bad), .o_underflow(b_unf), .o_level(b_level)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] fval(int i);
    return 32'hA5000000 + (32'(i) * 32'h00010203);
  endfunction

  initial begin
    a_fcs = '0; a_crc = '0; a_fcs_v = 1'b0; a_crc_v = 1'b0;
    b_fcs = '0; b_crc = '0; b_fcs_v = 1'b0; b_crc_v = 1'b0;

    // Reset state
    repeat (3) tick();
    check_eq("rst_tready", a_tready, 0);
    check_eq("rst_res_v",  a_res_v,  0);
    check_eq("rst_ok",     a_ok,     0);
    check_eq("rst_bad",    a_bad,    0);
    check_eq("rst_unf",    a_unf,    0);
    check_eq("rst_level",  a_level,  0);
    rst_n = 1'b1;
    tick(); tick();
    check_eq("tready_up", a_tready, 1);

    // Matching frame: FC891918 vs raw CRC 0376E6E7 (inverts to FC891918)
    a_fcs = 32'hFC891918; a_fcs_v = 1'b1;
    tick();
    a_fcs_v = 1'b0;
    check_eq("t1_level", a_level, 1);
    tick(); tick();
    a_crc = 32'h0376E6E7; a_crc_v = 1'b1;
    tick();
    a_crc_v = 1'b0;
    check_eq("t1_res_v",  a_res_v, 1);
    check_eq("t1_res",    a_res,   2'b01);
    check_eq("t1_ok",     a_ok,    1);
    check_eq("t1_bad",    a_bad,   0);
    check_eq("t1_level0", a_level, 0);
    tick();
    check_eq("t1_res_v_drop", a_res_v, 0);

    // Mismatching frame
    a_fcs = 32'hFC891919; a_fcs_v = 1'b1;
    tick();
    a_fcs_v = 1'b0;
    a_crc = 32'h0376E6E7; a_crc_v = 1'b1;
    tick();
    a_crc_v = 1'b0;
    check_eq("t2_res", a_res, 2'b00);
    check_eq("t2_bad", a_bad, 1);
    check_eq("t2_ok",  a_ok,  1);
    check_eq("t2_unf", a_unf, 0);

    // CRC on empty queue in the same cycle as a push: underflow, FCS kept
    a_fcs = 32'hFC891918; a_fcs_v = 1'b1;
    a_crc = 32'h0376E6E7; a_crc_v = 1'b1;
    tick();
    a_fcs_v = 1'b0;
    check_eq("t3_res_v",  a_res_v, 1);
    check_eq("t3_res",    a_res,   2'b10);
    check_eq("t3_unf",    a_unf,   1);
    check_eq("t3_bad",    a_bad,   2);
    check_eq("t3_level",  a_level, 1);
    tick();
    a_crc_v = 1'b0;
    check_eq("t3_pass",   a_res,   2'b01);
    check_eq("t3_ok",     a_ok,    2);
    check_eq("t3_unf_st", a_unf,   1);
    check_eq("t3_level0", a_level, 0);

    // Instance B: reflected output, no final XOR, then saturation
    b_fcs = 32'h80000000; b_fcs_v = 1'b1;
    tick();
    b_fcs_v = 1'b0;
    b_crc = 32'h00000001; b_crc_v = 1'b1;
    tick();
    check_eq("b_pass", b_res, 2'b01);
    check_eq("b_ok",   b_ok,  1);
    b_crc = 32'h12345678;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 13) check_eq("b_bad14", b_bad, 14);
      if (k == 14) check_eq("b_bad15", b_bad, 15);
    end
    b_crc_v = 1'b0;
    check_eq("b_bad_sat", b_bad, 15);
    check_eq("b_res_mis", b_res, 2'b10);
    check_eq("b_ok_keep", b_ok,  1);
    check_eq("b_unf",     b_unf, 1);

    // Fill A to full, hold a 17th push until one pop frees space
    for (int i = 0; i < 16; i++) begin
      a_fcs = fval(i); a_fcs_v = 1'b1;
      tick();
      model_q.push_back(fval(i));
    end
    a_fcs = fval(16);
    check_eq("full_level",  a_level,  16);
    check_eq("full_tready", a_tready, 0);
    tick(); tick();
    check_eq("full_hold", a_level, 16);
    a_crc = model_q[0] ^ 32'hFFFFFFFF; a_crc_v = 1'b1;
    tick();
    a_crc_v = 1'b0;
    void'(model_q.pop_front());
    check_eq("full_pop_res",    a_res,    2'b01);
    check_eq("full_pop_level",  a_level,  15);
    check_eq("full_pop_tready", a_tready, 1);
    tick();
    model_q.push_back(fval(16));
    a_fcs_v = 1'b0;
    check_eq("refill_level", a_level, 16);

    // 40 back-to-back frames across pointer wrap, pushing alongside
    nidx = 17;
    for (int j = 0; j < 40; j++) begin
      a_crc   = model_q[0] ^ 32'hFFFFFFFF;
      a_crc_v = 1'b1;
      a_fcs   = fval(nidx);
      a_fcs_v = (j < 30);
      acc     = a_fcs_v && a_tready;
      tick();
      void'(model_q.pop_front());
      if (acc) begin
        model_q.push_back(fval(nidx));
        nidx++;
      end
      check_eq("wrap_res", a_res, 2'b01);
    end
    a_crc_v = 1'b0;
    a_fcs_v = 1'b0;
    check_eq("wrap_level", a_level, 5);
    check_eq("wrap_ok",    a_ok,    2 + 1 + 40);

    // Asynchronous reset with level 5 and a CRC in flight
    a_crc = model_q[0] ^ 32'hFFFFFFFF; a_crc_v = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_res_v",  a_res_v,  0);
    check_eq("arst_res",    a_res,    0);
    check_eq("arst_ok",     a_ok,     0);
    check_eq("arst_bad",    a_bad,    0);
    check_eq("arst_unf",    a_unf,    0);
    check_eq("arst_level",  a_level,  0);
    check_eq("arst_tready", a_tready, 0);
    check_eq("arst_b_bad",  b_bad,    0);
    tick();
    a_crc_v = 1'b0;
    check_eq("arst_hold_v", a_res_v, 0);
    rst_n = 1'b1;
    tick(); tick();
    check_eq("post_tready", a_tready, 1);
    check_eq("post_level",  a_level,  0);
    check_eq("post_res_v",  a_res_v,  0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
